// File: rtl/tcb_lib_arbiter_pkg.sv
// Shared TCB types for the arbiter slice: configuration, request/response payloads
// and the index-width helper used to size grant and pointer registers.
package tcb_lib_arbiter_pkg;

    typedef struct packed {
        int unsigned dly;
        logic        hld;
    } tcb_hsk_t;

    typedef struct packed {
        int unsigned adr;
        int unsigned dat;
    } tcb_bus_t;

    typedef struct packed {
        tcb_hsk_t hsk;
        tcb_bus_t bus;
    } tcb_cfg_t;

    localparam tcb_cfg_t TCB_CFG_DEF = '{
        hsk: '{dly: 1, hld: 1'b1},
        bus: '{adr: 32, dat: 32}
    };

    typedef struct packed {
        logic        wen;
        logic [3:0]  ben;
        logic [31:0] adr;
        logic [31:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [31:0] rdt;
        logic        sts;
    } tcb_rsp_t;

    // A single port still needs a 1-bit index so that vectors never collapse to zero width.
    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcb_lib_arbiter_if.sv
// TCB point-to-point link: request channel with valid/ready handshake plus the
// response returned after the fixed handshake delay.
interface tcb_if;
    import tcb_lib_arbiter_pkg::*;

    logic     vld;
    tcb_req_t req;
    logic     rdy;
    tcb_rsp_t rsp;

    modport man (output vld, output req, input  rdy, input  rsp);
    modport sub (input  vld, input  req, output rdy, output rsp);

endinterface

// File: rtl/tcb_lib_arbiter_rr.sv
// Round-robin grant core: picks the first requester at or after ptr and holds the
// previous grant while lock is set.
module tcb_lib_arbiter_rr
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int unsigned IFN = 2,
    localparam int unsigned IW = idx_w(IFN)
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [IFN-1:0] req,
    input  logic           lock,
    input  logic           adv,
    output logic [IW-1:0]  gnt,
    output logic [IFN-1:0] gnt_oh
);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_q;
    logic [IW-1:0]    win;
    logic [2*IFN-1:0] dreq;
    logic             found;

    // Doubled vector masked from ptr upward: the upper copy supplies the wrapped candidates.
    always_comb begin
        dreq  = {req, req} & ({(2*IFN){1'b1}} << ptr);
        win   = ptr;
        found = 1'b0;
        for (int unsigned j = 0; j < 2*IFN; j++) begin
            if (!found && dreq[j]) begin
                found = 1'b1;
                win   = (j >= IFN) ? IW'(j - IFN) : IW'(j);
            end
        end
    end

    assign gnt    = lock ? gnt_q : win;
    assign gnt_oh = IFN'(1) << gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt;
            if (adv) begin
                ptr <= (gnt == IW'(IFN - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Shares one TCB subordinate port among IFN managers with round-robin arbitration;
// responses are steered back to the issuing manager after the handshake delay.
module tcb_lib_arbiter
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int unsigned IFN = 2,
    parameter tcb_cfg_t    CFG = TCB_CFG_DEF
)(
    input  logic clk,
    input  logic rst,
    tcb_if.sub   sub [IFN-1:0],
    tcb_if.man   man
);

    localparam int unsigned IW  = idx_w(IFN);
    localparam int unsigned DLY = CFG.hsk.dly;

    logic [IFN-1:0] req_vld;
    logic [IFN-1:0] req_rdy;
    logic [IFN-1:0] gnt_oh;
    tcb_req_t       req_dat [IFN];
    tcb_rsp_t       rsp_dat [IFN];
    logic [IW-1:0]  gnt;
    logic           lock;
    logic           man_vld;
    tcb_req_t       man_req;
    logic           xfer;
    logic           rsp_vld;
    logic [IW-1:0]  rsp_idx;

    for (genvar i = 0; i < IFN; i++) begin : g_port
        assign req_vld[i] = sub[i].vld;
        assign req_dat[i] = sub[i].req;
        assign sub[i].rdy = req_rdy[i];
        assign sub[i].rsp = rsp_dat[i];
    end

    tcb_lib_arbiter_rr #(
        .IFN (IFN)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req_vld),
        .lock   (lock),
        .adv    (xfer),
        .gnt    (gnt),
        .gnt_oh (gnt_oh)
    );

    always_comb begin
        man_vld = 1'b0;
        man_req = '0;
        for (int unsigned i = 0; i < IFN; i++) begin
            if (gnt_oh[i]) begin
                man_vld = req_vld[i];
                man_req = req_dat[i];
            end
        end
    end

    assign man.vld = man_vld;
    assign man.req = man_req;
    assign xfer    = man_vld & man.rdy;
    assign req_rdy = gnt_oh & {IFN{man.rdy}};

    // A stalled request is held by its manager, so the grant is frozen until it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock <= 1'b0;
        end else if (xfer) begin
            lock <= 1'b0;
        end else if (man_vld) begin
            lock <= 1'b1;
        end
    end

    if (DLY == 0) begin : g_nodly
        assign rsp_vld = xfer;
        assign rsp_idx = gnt;
    end else begin : g_pipe
        logic [DLY-1:0] pipe_vld;
        logic [IW-1:0]  pipe_idx [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_vld <= '0;
                for (int unsigned s = 0; s < DLY; s++) begin
                    pipe_idx[s] <= '0;
                end
            end else begin
                pipe_vld[0] <= xfer;
                pipe_idx[0] <= gnt;
                for (int unsigned s = 1; s < DLY; s++) begin
                    pipe_vld[s] <= pipe_vld[s-1];
                    pipe_idx[s] <= pipe_idx[s-1];
                end
            end
        end

        assign rsp_vld = pipe_vld[DLY-1];
        assign rsp_idx = pipe_idx[DLY-1];
    end

    always_comb begin
        for (int unsigned i = 0; i < IFN; i++) begin
            rsp_dat[i] = (rsp_vld && (rsp_idx == IW'(i))) ? man.rsp : '0;
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Directed bench for tcb_lib_arbiter: three IFN=3 instances with DLY=0,1,2 share the
// same manager stimulus; most scenarios are judged on the DLY=1 instance.
module tb_tcb_lib_arbiter;
    import tcb_lib_arbiter_pkg::*;

    localparam int unsigned IFN = 3;
    localparam int unsigned NK  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [IFN-1:0] vld;
    tcb_req_t       req [IFN];
    logic           man_rdy;

    logic [IFN-1:0] o_rdy  [NK];
    tcb_rsp_t       o_rsp  [NK][IFN];
    logic           o_mvld [NK];
    tcb_req_t       o_mreq [NK];
    logic [1:0]     ptr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Subordinate behaviour: writes echo wdt, reads return 0x1111_1111 * (word index + 1).
    function automatic tcb_rsp_t sub_model(tcb_req_t r);
        tcb_rsp_t p;
        p.sts = 1'b0;
        p.rdt = r.wen ? r.wdt : 32'h1111_1111 * ({30'd0, r.adr[3:2]} + 32'd1);
        return p;
    endfunction

    for (genvar k = 0; k < NK; k++) begin : g_dly
        localparam tcb_cfg_t C = '{hsk: '{dly: k, hld: 1'b1}, bus: '{adr: 32, dat: 32}};

        tcb_if    s_if [IFN-1:0] ();
        tcb_if    m_if ();
        tcb_rsp_t rsp_now;
        tcb_rsp_t rsp_d1;
        tcb_rsp_t rsp_d2;

        tcb_lib_arbiter #(
            .IFN (IFN),
            .CFG (C)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .sub (s_if),
            .man (m_if)
        );

        for (genvar i = 0; i < IFN; i++) begin : g_p
            assign s_if[i].vld = vld[i];
            assign s_if[i].req = req[i];
            assign o_rdy[k][i] = s_if[i].rdy;
            assign o_rsp[k][i] = s_if[i].rsp;
        end

        assign m_if.rdy  = man_rdy;
        assign rsp_now   = sub_model(m_if.req);
        always @(posedge clk) begin
            rsp_d1 <= rsp_now;
            rsp_d2 <= rsp_d1;
        end
        assign m_if.rsp  = (k == 0) ? rsp_now : (k == 1) ? rsp_d1 : rsp_d2;
        assign o_mvld[k] = m_if.vld;
        assign o_mreq[k] = m_if.req;
    end

    assign ptr1 = g_dly[1].u_dut.u_rr.ptr;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; vld = '0; man_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; man_rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; vld = '0; man_rdy = 1'b0;
        for (int i = 0; i < int'(IFN); i++) begin
            req[i] = '{wen: 1'b0, ben: 4'hF, adr: 32'(4*i), wdt: 32'd0};
        end
        @(negedge clk);
        checks++; if (o_mvld[1] !== 1'b0) begin errors++; $display("FAIL reset_man_vld: got %b expected 0", o_mvld[1]); end
        checks++; if (o_rdy[1] !== 3'b000) begin errors++; $display("FAIL reset_sub_rdy: got %b expected 000", o_rdy[1]); end
        checks++; if (ptr1 !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr1); end
        checks++; if (o_rsp[1][0] !== tcb_rsp_t'('0)) begin errors++; $display("FAIL reset_rsp: got %h expected 0", o_rsp[1][0]); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        tcb_req_t exp_req;
        tcb_rsp_t exp_rsp;
        exp_req = '{wen: 1'b1, ben: 4'hF, adr: 32'h0000_0010, wdt: 32'hCAFE_F00D};
        exp_rsp = '{rdt: 32'hCAFE_F00D, sts: 1'b0};
        @(posedge clk); #1;
        req[1] = '{wen: 1'b1, ben: 4'hF, adr: 32'h0000_0010, wdt: 32'hCAFE_F00D};
        vld = 3'b010; man_rdy = 1'b1;
        @(negedge clk);
        checks++; if (o_mvld[1] !== 1'b1) begin errors++; $display("FAIL single_man_vld: got %b expected 1", o_mvld[1]); end
        checks++; if (o_mreq[1] !== exp_req) begin errors++; $display("FAIL single_man_req: got %h expected %h", o_mreq[1], exp_req); end
        checks++; if (o_rdy[1] !== 3'b010) begin errors++; $display("FAIL single_sub_rdy: got %b expected 010", o_rdy[1]); end
        @(posedge clk); #1;
        vld = '0;
        @(negedge clk);
        checks++; if (o_rsp[1][1] !== exp_rsp) begin errors++; $display("FAIL single_rsp: got %h expected %h", o_rsp[1][1], exp_rsp); end
        checks++; if (o_rsp[1][0] !== tcb_rsp_t'('0)) begin errors++; $display("FAIL single_rsp_other: got %h expected 0", o_rsp[1][0]); end
        checks++; if (ptr1 !== 2'd2) begin errors++; $display("FAIL single_ptr: got %0d expected 2", ptr1); end
    endtask

    task automatic test_all_three();
        logic [2:0] ones;
        logic [2:0] exp_rdy;
        tcb_rsp_t   exp_rsp;
        ones = 3'b111;
        do_reset();
        for (int i = 0; i < int'(IFN); i++) begin
            req[i] = '{wen: 1'b0, ben: 4'hF, adr: 32'(4*i), wdt: 32'd0};
        end
        for (int c = 0; c < 5; c++) begin
            vld = (c < 3) ? (ones << c) : 3'b000;
            @(negedge clk);
            for (int k = 0; k < int'(NK); k++) begin
                if (c < 3) begin
                    exp_rdy = 3'b001 << c;
                    checks++; if (o_rdy[k] !== exp_rdy) begin errors++; $display("FAIL all3_gnt k%0d c%0d: got %b expected %b", k, c, o_rdy[k], exp_rdy); end
                end
                for (int i = 0; i < int'(IFN); i++) begin
                    exp_rsp = (c == i + k) ? '{rdt: 32'h1111_1111 * 32'(i + 1), sts: 1'b0} : '0;
                    checks++; if (o_rsp[k][i] !== exp_rsp) begin errors++; $display("FAIL all3_rsp k%0d p%0d c%0d: got %h expected %h", k, i, c, o_rsp[k][i], exp_rsp); end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_rdy;
        req[0] = '{wen: 1'b0, ben: 4'hF, adr: 32'h0000_0020, wdt: 32'd0};
        req[2] = '{wen: 1'b0, ben: 4'hF, adr: 32'h0000_0028, wdt: 32'd0};
        vld = 3'b100;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) vld = 3'b101;
            man_rdy = (c == 3);
            @(negedge clk);
            exp_rdy = (c == 3) ? 3'b100 : 3'b000;
            checks++; if (o_mreq[1].adr !== 32'h0000_0028) begin errors++; $display("FAIL stall_gnt c%0d: got adr %h expected 00000028", c, o_mreq[1].adr); end
            checks++; if (o_rdy[1] !== exp_rdy) begin errors++; $display("FAIL stall_rdy c%0d: got %b expected %b", c, o_rdy[1], exp_rdy); end
            @(posedge clk); #1;
        end
        vld = 3'b001;
        @(negedge clk);
        checks++; if (o_rdy[1] !== 3'b001) begin errors++; $display("FAIL stall_next_rdy: got %b expected 001", o_rdy[1]); end
        checks++; if (o_mreq[1].adr !== 32'h0000_0020) begin errors++; $display("FAIL stall_next_adr: got %h expected 00000020", o_mreq[1].adr); end
        @(posedge clk); #1;
        vld = '0;
        @(negedge clk);
        checks++; if (ptr1 !== 2'd1) begin errors++; $display("FAIL stall_ptr: got %0d expected 1", ptr1); end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_rdy;
        logic [1:0] exp_ptr;
        @(posedge clk); #1;
        vld = 3'b101; man_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_rdy = (c % 2 == 0) ? 3'b100 : 3'b001;
            exp_ptr = (c % 2 == 0) ? 2'd1 : 2'd0;
            checks++; if (o_rdy[1] !== exp_rdy) begin errors++; $display("FAIL wrap_gnt c%0d: got %b expected %b", c, o_rdy[1], exp_rdy); end
            checks++; if (ptr1 !== exp_ptr) begin errors++; $display("FAIL wrap_ptr c%0d: got %0d expected %0d", c, ptr1, exp_ptr); end
            @(posedge clk); #1;
        end
        vld = '0;
        @(negedge clk);
        checks++; if (ptr1 !== 2'd1) begin errors++; $display("FAIL wrap_ptr_end: got %0d expected 1", ptr1); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req[1] = '{wen: 1'b0, ben: 4'hF, adr: 32'h0000_0004, wdt: 32'd0};
        vld = 3'b010; man_rdy = 1'b1;
        @(negedge clk);
        checks++; if (o_rdy[1] !== 3'b010) begin errors++; $display("FAIL rstmid_hsk: got %b expected 010", o_rdy[1]); end
        @(posedge clk); #1;
        vld = '0; rst = 1'b0;
        @(negedge clk);
        checks++; if (o_rsp[1][1] !== tcb_rsp_t'('0)) begin errors++; $display("FAIL rstmid_rsp_d1: got %h expected 0", o_rsp[1][1]); end
        checks++; if (o_mvld[1] !== 1'b0) begin errors++; $display("FAIL rstmid_man_vld: got %b expected 0", o_mvld[1]); end
        checks++; if (ptr1 !== 2'd0) begin errors++; $display("FAIL rstmid_ptr: got %0d expected 0", ptr1); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < int'(IFN); i++) begin
            req[i] = '{wen: 1'b0, ben: 4'hF, adr: 32'(4*i), wdt: 32'd0};
        end
        vld = 3'b111;
        @(negedge clk);
        checks++; if (o_rdy[1] !== 3'b001) begin errors++; $display("FAIL rstmid_first_gnt: got %b expected 001", o_rdy[1]); end
        checks++; if (o_rsp[2][1] !== tcb_rsp_t'('0)) begin errors++; $display("FAIL rstmid_rsp_d2: got %h expected 0", o_rsp[2][1]); end
        @(posedge clk); #1;
        vld = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_three();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
